// File: rtl/psram_qpi_responder_if.sv
// rtl/psram_qpi_responder_if.sv - QPI PSRAM link bundle between initiator and responder
// The inout pad is split into sampled input, registered drive value and output enable.
interface psram_qpi_responder_if;
  logic       mem_ce;
  logic [3:0] mem_sio;
  logic [3:0] sio_drive;
  logic       sio_oe;

  modport master (output mem_ce, mem_sio, input sio_drive, sio_oe);
  modport slave  (input mem_ce, mem_sio, output sio_drive, sio_oe);
endinterface

// File: rtl/psram_qpi_responder.sv
// rtl/psram_qpi_responder.sv - QPI PSRAM device-side responder with internal byte array
// Optional PSRAM_QPI_EXIT_EN: QPI opcode 0xF5 leaves QPI mode when mem_ce rises.
module psram_qpi_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 6
) (
  input  logic                      mem_clk,
  input  logic                      rst,
  psram_qpi_responder_if.slave      bus,
  output logic                      qpi_mode,
  output logic                      busy,
  output logic                      cmd_err,
  output logic [7:0]                last_cmd
);

  typedef enum logic [2:0] {
    IDLE, SPI_CMD, QPI_CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA, IGNORE
  } state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [6:0]        sh;
  logic [ADDR_W-1:0] ptr;
  logic              phase;
  logic              wr_op;
  logic              rst_en;
  logic              armed;
  logic              qpi_set_pend;
  logic              qpi_clr_pend;
  logic [7:0]        mem [0:(2**ADDR_W)-1];

  logic [3:0] nib;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       is_access;

  always_comb begin
    nib       = bus.mem_sio;
    rx_byte   = qpi_mode ? {sh[3:0], nib} : {sh[6:0], nib[0]};
    byte_done = (state == QPI_CMD) || (state == SPI_CMD && cnt == 8'd7);
    is_access = qpi_mode && (rx_byte == 8'hEB || rx_byte == 8'h38);
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      sh            <= 7'd0;
      ptr           <= '0;
      phase         <= 1'b0;
      wr_op         <= 1'b0;
      rst_en        <= 1'b0;
      armed         <= 1'b0;
      qpi_set_pend  <= 1'b0;
      qpi_clr_pend  <= 1'b0;
      qpi_mode      <= 1'b0;
      busy          <= 1'b0;
      cmd_err       <= 1'b0;
      last_cmd      <= 8'h00;
      bus.sio_drive <= 4'h0;
      bus.sio_oe    <= 1'b0;
    end else if (bus.mem_ce) begin
      // Mode changes land on the frame boundary so the current frame decodes consistently.
      state        <= IDLE;
      bus.sio_oe   <= 1'b0;
      busy         <= 1'b0;
      armed        <= 1'b1;
      qpi_set_pend <= 1'b0;
      qpi_clr_pend <= 1'b0;
      if (qpi_set_pend) qpi_mode <= 1'b1;
      if (qpi_clr_pend) qpi_mode <= 1'b0;
    end else if (byte_done) begin
      last_cmd <= rx_byte;
      rst_en   <= (rx_byte == 8'h66);
      wr_op    <= (rx_byte == 8'h38);
      cnt      <= 8'd0;
      state    <= is_access ? ADDR : IGNORE;
      case (rx_byte)
        8'h66: ;
        8'h99: begin
          if (rst_en) begin
            cmd_err      <= 1'b0;
            qpi_clr_pend <= 1'b1;
          end else begin
            cmd_err <= 1'b1;
          end
        end
        8'h35: qpi_set_pend <= 1'b1;
        8'hEB, 8'h38: if (!qpi_mode) cmd_err <= 1'b1;
`ifdef PSRAM_QPI_EXIT_EN
        8'hF5: if (qpi_mode) qpi_clr_pend <= 1'b1; else cmd_err <= 1'b1;
`endif
        default: cmd_err <= 1'b1;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (armed) begin
            busy  <= 1'b1;
            cnt   <= 8'd1;
            sh    <= qpi_mode ? {3'b000, nib} : {6'd0, nib[0]};
            state <= qpi_mode ? QPI_CMD : SPI_CMD;
          end
        end
        SPI_CMD: begin
          sh  <= {sh[5:0], nib[0]};
          cnt <= cnt + 8'd1;
        end
        ADDR: begin
          // Shifting all six nibbles through the pointer keeps only A[ADDR_W-1:0].
          ptr <= ADDR_W'({ptr, nib});
          cnt <= cnt + 8'd1;
          if (cnt == 8'd5) begin
            phase <= 1'b0;
            if (wr_op)                 state <= WR_DATA;
            else if (WAIT_CYCLES == 0) state <= RD_DATA;
            else begin
              state <= RD_WAIT;
              cnt   <= 8'(WAIT_CYCLES);
            end
          end
        end
        WR_DATA: begin
          phase <= ~phase;
          if (!phase) begin
            sh[3:0] <= nib;
          end else begin
            mem[ptr] <= {sh[3:0], nib};
            ptr      <= ptr + 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt == 8'd1) state <= RD_DATA;
          else             cnt   <= cnt - 8'd1;
        end
        RD_DATA: begin
          bus.sio_oe <= 1'b1;
          phase      <= ~phase;
          if (!phase) begin
            bus.sio_drive <= mem[ptr][7:4];
          end else begin
            bus.sio_drive <= mem[ptr][3:0];
            ptr           <= ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
